// File: rtl/wdt_supervisor.sv
// Supervisory controller for watchdog_timer: heartbeat vote, trip recovery (mute, hold, re-arm), lockout.
// Optional WDT_SUPERVISOR_WARN_MUTE_EN: in ARMED, rf_mute follows wd_warning one cycle later.
module wdt_supervisor #(
  parameter int NUM_SRC     = 2,
  parameter int MUTE_CYCLES = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int MAX_FAULTS  = 3,
  parameter int FCNT_W      = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  input  logic [NUM_SRC-1:0] src_kick,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               clear_lock,
  input  logic               wd_warning,
  input  logic               wd_force_reset,
  output logic               wd_enable,
  output logic               wd_heartbeat,
  output logic               rf_mute,
  output logic               sys_rstn,
  output logic [FCNT_W-1:0]  fault_count,
  output logic               locked,
  output logic [2:0]         state
);

  localparam int DWELL_MAX = (MUTE_CYCLES > HOLD_CYCLES) ? MUTE_CYCLES : HOLD_CYCLES;
  localparam int DW = $clog2(DWELL_MAX + 1);
  localparam logic [DW-1:0]     MUTE_LD = DW'(MUTE_CYCLES - 1);
  localparam logic [DW-1:0]     HOLD_LD = DW'(HOLD_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_SAT = '1;
  localparam logic [FCNT_W-1:0] FAULT_LIM = FCNT_W'(MAX_FAULTS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    MUTE   = 3'd2,
    HOLD   = 3'd3,
    REARM  = 3'd4,
    LOCKED = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [FCNT_W-1:0]   fault_q, fault_d;
  logic                hb_q, hb_d;
  logic                wd_enable_q, wd_enable_d;
  logic                rf_mute_q, rf_mute_d;
  logic                sys_rstn_q, sys_rstn_d;
  logic                locked_q, locked_d;
  logic                warn_mute_d;
  logic                vote_done;

`ifndef WDT_SUPERVISOR_WARN_MUTE_EN
  logic unused_warning;
  assign unused_warning = wd_warning;
`endif

  // Masked-out sources count as satisfied; an all-zero mask can never complete.
  assign vote_done = (|src_mask) && (&(pending_q | src_kick | ~src_mask));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    dwell_d     = dwell_q;
    fault_d     = fault_q;
    hb_d        = 1'b0;
    warn_mute_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = ARMED;
          pending_d = '0;
        end
      end
      ARMED: begin
        if (wd_force_reset) begin
          state_d   = MUTE;
          dwell_d   = MUTE_LD;
          pending_d = '0;
          fault_d   = (fault_q == FCNT_SAT) ? fault_q : fault_q + FCNT_W'(1);
        end else if (!arm) begin
          state_d = IDLE;
        end else if (vote_done) begin
          hb_d      = 1'b1;
          pending_d = '0;
        end else begin
          pending_d = pending_q | src_kick;
        end
`ifdef WDT_SUPERVISOR_WARN_MUTE_EN
        warn_mute_d = arm && !wd_force_reset && wd_warning;
`endif
      end
      MUTE: begin
        if (dwell_q == '0) begin
          state_d = HOLD;
          dwell_d = HOLD_LD;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      HOLD: begin
        if (dwell_q == '0) begin
          state_d = (fault_q >= FAULT_LIM) ? LOCKED : REARM;
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      REARM: begin
        pending_d = '0;
        state_d   = arm ? ARMED : IDLE;
      end
      LOCKED: begin
        if (clear_lock) begin
          state_d = IDLE;
          fault_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    wd_enable_d = (state_d == ARMED);
    rf_mute_d   = (state_d == MUTE) || (state_d == HOLD) || (state_d == REARM) ||
                  (state_d == LOCKED) || warn_mute_d;
    sys_rstn_d  = (state_d != HOLD);
    locked_d    = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      dwell_q     <= '0;
      fault_q     <= '0;
      hb_q        <= 1'b0;
      wd_enable_q <= 1'b0;
      rf_mute_q   <= 1'b0;
      sys_rstn_q  <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dwell_q     <= dwell_d;
      fault_q     <= fault_d;
      hb_q        <= hb_d;
      wd_enable_q <= wd_enable_d;
      rf_mute_q   <= rf_mute_d;
      sys_rstn_q  <= sys_rstn_d;
      locked_q    <= locked_d;
    end
  end

  assign wd_enable    = wd_enable_q;
  assign wd_heartbeat = hb_q;
  assign rf_mute      = rf_mute_q;
  assign sys_rstn     = sys_rstn_q;
  assign fault_count  = fault_q;
  assign locked       = locked_q;
  assign state        = state_q;

endmodule

// File: tb/tb_wdt_supervisor.sv
// Bench for wdt_supervisor: directed scenarios with literal checks, then random stimulus
// compared every cycle against a timeline-based reference model.
module tb_wdt_supervisor;
  localparam int NUM_SRC = 2;
  localparam int MUTE    = 16;
  localparam int HOLD    = 64;
  localparam int MAXF    = 3;
  localparam int FW      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, arm, clear_lock, wd_warning, wd_force_reset;
  logic [NUM_SRC-1:0] src_kick, src_mask;
  logic               wd_enable, wd_heartbeat, rf_mute, sys_rstn, locked;
  logic [FW-1:0]      fault_count;
  logic [2:0]         state;

  wdt_supervisor #(
    .NUM_SRC(NUM_SRC), .MUTE_CYCLES(MUTE), .HOLD_CYCLES(HOLD),
    .MAX_FAULTS(MAXF), .FCNT_W(FW)
  ) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .src_kick(src_kick), .src_mask(src_mask),
    .clear_lock(clear_lock), .wd_warning(wd_warning), .wd_force_reset(wd_force_reset),
    .wd_enable(wd_enable), .wd_heartbeat(wd_heartbeat), .rf_mute(rf_mute),
    .sys_rstn(sys_rstn), .fault_count(fault_count), .locked(locked), .state(state)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: supervising flag, lock flag, and time elapsed since the last trip.
  bit                 m_active, m_lock, e_hb, e_wm;
  int                 m_rec, m_faults;
  bit [NUM_SRC-1:0]   m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_state();
    if (m_lock) return 5;
    if (m_rec > 0) begin
      if (m_rec <= MUTE) return 2;
      if (m_rec <= MUTE + HOLD) return 3;
      return 4;
    end
    return m_active ? 1 : 0;
  endfunction

  task automatic model_edge();
    bit was_active, all_in;
    e_hb = 1'b0;
    e_wm = 1'b0;
    if (!rstn) begin
      m_active = 0; m_lock = 0; m_rec = 0; m_faults = 0; m_pend = '0;
      return;
    end
    was_active = m_active;
    if (m_rec > 0) begin
      if (m_rec == MUTE + HOLD && m_faults >= MAXF) begin
        m_lock = 1; m_rec = 0;
      end else if (m_rec == MUTE + HOLD + 1) begin
        m_rec = 0; m_active = arm; m_pend = '0;
      end else begin
        m_rec++;
      end
    end else if (m_lock) begin
      if (clear_lock) begin
        m_lock = 0; m_faults = 0;
      end
    end else if (m_active) begin
      if (wd_force_reset) begin
        m_rec = 1; m_active = 0; m_pend = '0;
        if (m_faults < (1 << FW) - 1) m_faults++;
      end else if (!arm) begin
        m_active = 0;
      end else begin
        all_in = (src_mask != '0);
        for (int i = 0; i < NUM_SRC; i++)
          if (src_mask[i] && !(m_pend[i] || src_kick[i])) all_in = 0;
        if (all_in) begin
          e_hb = 1; m_pend = '0;
        end else begin
          m_pend = m_pend | src_kick;
        end
      end
    end else if (arm) begin
      m_active = 1; m_pend = '0;
    end
`ifdef WDT_SUPERVISOR_WARN_MUTE_EN
    e_wm = was_active && m_active && wd_warning;
`else
    e_wm = was_active && 1'b0;
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("state", state, exp_state());
    chk("wd_enable", wd_enable, m_active && m_rec == 0 && !m_lock);
    chk("wd_heartbeat", wd_heartbeat, e_hb);
    chk("rf_mute", rf_mute, (m_rec > 0) || m_lock || e_wm);
    chk("sys_rstn", sys_rstn, !(m_rec > MUTE && m_rec <= MUTE + HOLD));
    chk("fault_count", fault_count, m_faults);
    chk("locked", locked, m_lock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_trip();
    wd_force_reset = 1; step();
    wd_force_reset = 0; steps(MUTE + HOLD);
  endtask

  initial begin
    rstn = 0; arm = 0; clear_lock = 0; wd_warning = 0; wd_force_reset = 0;
    src_kick = '0; src_mask = '0;
    steps(2);
    chk("reset_state", state, 0);
    chk("reset_sys_rstn", sys_rstn, 1);

    // Heartbeat vote across two sources
    rstn = 1; src_mask = 2'b11; arm = 1; step();
    chk("armed_enable", wd_enable, 1);
    steps(3);
    src_kick = 2'b01; step();
    src_kick = 2'b00; steps(3);
    chk("hb_early", wd_heartbeat, 0);
    src_kick = 2'b10; step();
    src_kick = 2'b00;
    chk("hb_vote", wd_heartbeat, 1);
    step();
    chk("hb_one_cycle", wd_heartbeat, 0);
    src_kick = 2'b11; step();
    chk("hb_same_cycle", wd_heartbeat, 1);
    src_kick = 2'b01; step();
    chk("hb_next_vote_empty", wd_heartbeat, 0);
    src_kick = 2'b00; step();

    // Masked sources
    src_mask = 2'b01;
    for (int k = 0; k < 3; k++) begin
      src_kick = 2'b01; step();
      chk("hb_masked", wd_heartbeat, 1);
      src_kick = 2'b00; steps(7);
    end
    src_mask = 2'b00;
    for (int k = 0; k < 10; k++) begin
      src_kick = 2'($urandom_range(0, 3)); step();
    end
    src_kick = 2'b00;

    // Trip sequence timeline
    src_mask = 2'b11;
    wd_force_reset = 1; step();
    wd_force_reset = 0;
    chk("trip_state", state, 2);
    chk("trip_mute", rf_mute, 1);
    chk("trip_fault", fault_count, 1);
    steps(MUTE - 1);
    chk("mute_last_rstn", sys_rstn, 1);
    step();
    chk("hold_state", state, 3);
    chk("hold_rstn", sys_rstn, 0);
    steps(HOLD - 1);
    chk("hold_last_rstn", sys_rstn, 0);
    step();
    chk("rearm_state", state, 4);
    chk("rearm_rstn", sys_rstn, 1);
    step();
    chk("rearmed_state", state, 1);
    chk("rearmed_mute", rf_mute, 0);

    // Lockout after the third trip
    do_trip();
    step();
    do_trip();
    chk("lock_state", state, 5);
    chk("lock_flag", locked, 1);
    chk("lock_fault", fault_count, 3);
    steps(3);
    chk("lock_ignores_arm", state, 5);
    clear_lock = 1; step();
    clear_lock = 0;
    chk("clear_state", state, 0);
    chk("clear_fault", fault_count, 0);
    step();

    // Trip together with vote completion, then reset during HOLD
    src_kick = 2'b11; wd_force_reset = 1; step();
    src_kick = 2'b00; wd_force_reset = 0;
    chk("trip_beats_vote_hb", wd_heartbeat, 0);
    chk("trip_beats_vote_state", state, 2);
    steps(MUTE + 5);
    chk("mid_hold_rstn", sys_rstn, 0);
    rstn = 0; step();
    chk("abort_state", state, 0);
    chk("abort_sys_rstn", sys_rstn, 1);
    chk("abort_fault", fault_count, 0);
    rstn = 1;

    // Warning-driven mute
    step();
    wd_warning = 1;
    for (int k = 0; k < 5; k++) begin
      step();
`ifdef WDT_SUPERVISOR_WARN_MUTE_EN
      chk("warn_mute", rf_mute, 1);
`else
      chk("warn_mute", rf_mute, 0);
`endif
    end
    wd_warning = 0; step();
    chk("warn_mute_drop", rf_mute, 0);

    // Random stimulus
    for (int k = 0; k < 4000; k++) begin
      rstn           = ($urandom_range(0, 299) != 0);
      arm            = ($urandom_range(0, 15) != 0);
      src_kick       = NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1));
      if ($urandom_range(0, 15) == 0)
        src_mask     = NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1));
      wd_force_reset = ($urandom_range(0, 59) == 0);
      wd_warning     = ($urandom_range(0, 3) == 0);
      clear_lock     = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
